mcu_scheduler: RTL

MCU_SCHEDULER -- requirements
Module: mcu_scheduler

---
 rtl/mcu_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mcu_scheduler.sv
// mcu_scheduler: paces Huffman decode, block handoff and restart-marker recovery across one frame of MCUs.
// Restart-marker support (RSTM state, restart counter) is built only when RESTART_INTERVAL_EN is defined.
module mcu_scheduler #(
  parameter int MCU_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [MCU_W-1:0] num_mcu_i,
  input  logic [MCU_W-1:0] restart_interval_i,
  input  logic             ibuff_valid_i,
  input  logic             sym_valid_i,
  input  logic             block_done_i,
  input  logic             out_ready_i,
  input  logic             marker_seen_i,
  output logic             dec_en_o,
  output logic             freq_o,
  output logic [1:0]       ch_o,
  output logic             pred_clear_o,
  output logic             block_valid_o,
  output logic [1:0]       ch_out_o,
  output logic [MCU_W-1:0] mcu_idx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // WAIT   | waiting for decodable input bits
  // DC     | decoding DC symbol
  // AC     | decoding AC symbols until block complete
  // HOLD   | presenting finished block downstream
  // RSTM   | waiting for RSTn marker
  // DONE   | one-cycle end-of-frame pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DC, S_AC, S_HOLD, S_RSTM, S_DONE
  } state_e;

  state_e           state_q;
  logic             mode_q;
  logic [MCU_W-1:0] num_mcu_q;
  logic [MCU_W-1:0] mcu_idx_q;
  logic [2:0]       blk_q;
  logic             pred_clear_q;
  logic             blk_wrap;
  logic             last_mcu;
  logic             rst_hit;
  logic [1:0]       ch;

  assign blk_wrap = (blk_q == (mode_q ? 3'd2 : 3'd5));
  assign last_mcu = (mcu_idx_q == num_mcu_q - MCU_W'(1));

`ifdef RESTART_INTERVAL_EN
  logic [MCU_W-1:0] ri_q;
  logic [MCU_W-1:0] rcnt_q;
  assign rst_hit = (ri_q != '0) && (rcnt_q + MCU_W'(1) == ri_q);
`else
  logic unused_restart;
  assign unused_restart = ^{restart_interval_i, marker_seen_i};
  assign rst_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      num_mcu_q    <= '0;
      mcu_idx_q    <= '0;
      blk_q        <= 3'd0;
      pred_clear_q <= 1'b0;
`ifdef RESTART_INTERVAL_EN
      ri_q         <= '0;
      rcnt_q       <= '0;
`endif
    end else begin
      pred_clear_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q       <= mode_i;
            num_mcu_q    <= num_mcu_i;
            mcu_idx_q    <= '0;
            blk_q        <= 3'd0;
            pred_clear_q <= 1'b1;
`ifdef RESTART_INTERVAL_EN
            ri_q         <= restart_interval_i;
            rcnt_q       <= '0;
`endif
            state_q      <= (num_mcu_i == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: if (ibuff_valid_i) state_q <= S_DC;
        S_DC:   if (sym_valid_i) state_q <= S_AC;
        S_AC:   if (block_done_i) state_q <= S_HOLD;
        S_HOLD: begin
          if (out_ready_i) begin
            if (!blk_wrap) begin
              blk_q   <= blk_q + 3'd1;
              state_q <= S_WAIT;
            end else begin
              blk_q <= 3'd0;
              // mcu_idx stops at the last MCU, so it can never run past num_mcu-1
              if (last_mcu) begin
                state_q <= S_DONE;
              end else begin
                mcu_idx_q <= mcu_idx_q + MCU_W'(1);
                if (rst_hit) begin
                  state_q <= S_RSTM;
                end else begin
                  state_q <= S_WAIT;
`ifdef RESTART_INTERVAL_EN
                  if (ri_q != '0) rcnt_q <= rcnt_q + MCU_W'(1);
`endif
                end
              end
            end
          end
        end
`ifdef RESTART_INTERVAL_EN
        S_RSTM: begin
          if (marker_seen_i) begin
            rcnt_q       <= '0;
            pred_clear_q <= 1'b1;
            state_q      <= S_WAIT;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ch = 2'd0;
    if (mode_q)              ch = blk_q[1:0];
    else if (blk_q == 3'd4)  ch = 2'd1;
    else if (blk_q == 3'd5)  ch = 2'd2;
  end

  assign dec_en_o      = (state_q == S_DC) || (state_q == S_AC);
  assign freq_o        = (state_q == S_AC);
  assign ch_o          = ch;
  assign pred_clear_o  = pred_clear_q;
  assign block_valid_o = (state_q == S_HOLD);
  assign ch_out_o      = (state_q == S_HOLD) ? ch : 2'd0;
  assign mcu_idx_o     = mcu_idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_done_o  = (state_q == S_DONE);

endmodule
